// File: rtl/serial_negate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_pkg
// Brief   : Shared state type and default width for the serial negate TX.
// Revision: 1.0 - initial release
// ============================================================================
package serial_negate_pkg;

    localparam int SNTX_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sntx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_negate_bit.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_bit
// Brief   : Serial two's-complement negation: seen_one flag and invert mux.
// Revision: 1.0 - initial release
// ============================================================================
module serial_negate_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic neg,
    input  logic bit_valid,
    input  logic raw_bit,
    output logic out_bit
);

    logic r_seen_one;

    // Clear wins over set so a back-to-back accept starts the new word fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen_one <= 1'b0;
        end else if (clear) begin
            r_seen_one <= 1'b0;
        end else if (bit_valid && raw_bit) begin
            r_seen_one <= 1'b1;
        end
    end

    assign out_bit = bit_valid & (raw_bit ^ (neg & r_seen_one));

endmodule
`default_nettype wire

// File: rtl/serial_negate_tx.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_tx
// Brief   : Parallel-in, LSB-first serial transmitter with optional
//           two's-complement negation. Define SERIAL_NEGATE_TX_PARITY_EN to
//           append an even-parity bit to each frame.
// Revision: 1.0 - initial release
// ============================================================================
module serial_negate_tx
    import serial_negate_pkg::*;
#(
    parameter int WIDTH = SNTX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_neg,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);

    sntx_state_t        r_state;
    sntx_state_t        w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_neg;
    logic               w_accept;
    logic               w_last_data;
    logic               w_shift_valid;
    logic               w_bit;

    assign w_last_data = (r_state == SHIFT) && (r_cnt == c_last_idx);
    assign w_accept    = in_valid & in_ready & rst_n;

`ifdef SERIAL_NEGATE_TX_PARITY_EN
    logic r_parity;

    assign in_ready = (r_state == IDLE) || (r_state == PARITY);
    assign ser_out  = (r_state == PARITY) ? r_parity : w_bit;

    // Parity is accumulated over the bits as sent, i.e. after negation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= 1'b0;
        end else if (w_shift_valid) begin
            r_parity <= r_parity ^ w_bit;
        end
    end
`else
    assign in_ready = (r_state == IDLE) || w_last_data;
    assign ser_out  = w_bit;
`endif

    always_comb begin
        w_next_state  = r_state;
        ser_valid     = 1'b0;
        ser_last      = 1'b0;
        w_shift_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid     = 1'b1;
                w_shift_valid = 1'b1;
                if (w_last_data) begin
`ifdef SERIAL_NEGATE_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    ser_last     = 1'b1;
                    w_next_state = w_accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef SERIAL_NEGATE_TX_PARITY_EN
                ser_valid    = 1'b1;
                ser_last     = 1'b1;
                w_next_state = w_accept ? SHIFT : IDLE;
`else
                w_next_state = IDLE;
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_shift <= in_data;
                r_neg   <= in_neg;
                r_cnt   <= '0;
            end else if (w_shift_valid) begin
                r_shift <= r_shift >> 1;
                r_cnt   <= w_last_data ? '0 : r_cnt + c_cnt_w'(1);
            end
        end
    end

    serial_negate_bit u_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_accept),
        .neg       (r_neg),
        .bit_valid (w_shift_valid),
        .raw_bit   (r_shift[0]),
        .out_bit   (w_bit)
    );

endmodule
`default_nettype wire

// File: doc/serial_negate_tx.md
SERIAL_NEGATE_TX -- requirements
Module: serial_negate_tx

Interface
REQ-001 Parameter WIDTH, default 8, is the number of data bits per frame; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-003 Port rst_n, input, 1 bit, is the reset; it is synchronous and active-low.
REQ-004 Port in_data, input, WIDTH bits, is the parallel word to transmit.
REQ-005 Port in_neg, input, 1 bit, requests two's-complement negation of in_data; it is sampled with in_data.
REQ-006 Port in_valid, input, 1 bit, means in_data and in_neg are valid.
REQ-007 Port in_ready, output, 1 bit, means a word is accepted this cycle if in_valid=1.
REQ-008 Port ser_out, output, 1 bit, is the serial bit, sent LSB first.
REQ-009 Port ser_valid, output, 1 bit, means ser_out carries a frame bit this cycle.
REQ-010 Port ser_last, output, 1 bit, marks the final bit of a frame.

Function
REQ-011 A word is accepted only when in_valid=1 and in_ready=1 on the same rising edge, and it is latched into a WIDTH-bit shift register.
REQ-012 There are two states, IDLE and SHIFT (plus PARITY, see REQ-024):
- IDLE to SHIFT on accept.
- SHIFT stays in SHIFT for WIDTH cycles.
- On the final bit, SHIFT goes back to SHIFT if a new word is accepted, otherwise to IDLE.
REQ-013 Latency: the first bit appears on ser_out with ser_valid=1 in the cycle after the accept edge.
REQ-014 The frame lasts exactly WIDTH consecutive ser_valid cycles with no gaps.
REQ-015 in_ready=1 in IDLE, and also in the final-bit cycle of a frame, so that back-to-back frames have zero idle cycles; in_ready=0 in all other cycles.
REQ-016 Negation is Mealy style. A flag seen_one clears on accept and sets after the first transmitted raw bit that equals 1.
- ser_out = raw bit when in_neg was 0, or when seen_one=0.
- ser_out = inverted raw bit when in_neg was 1 and seen_one=1.
REQ-017 Negation wraps modulo 2^WIDTH:
- 0 negated gives 0.
- The most negative value (MSB only set) negated gives itself.
- No overflow flag exists.
REQ-018 A bit counter counts 0 to WIDTH-1 and sets ser_last=1 when it equals WIDTH-1. With parity enabled, ser_last instead marks the parity bit.
REQ-019 The downstream side has no backpressure; ser_valid is never stalled.
REQ-020 When ser_valid=0, ser_out and ser_last are 0.
REQ-021 A change on in_valid while in_ready=0 has no effect.

Reset
REQ-022 When rst_n=0 on a rising edge:
- state goes to IDLE; counter, shift register and seen_one go to 0.
- The outputs are in_ready=1, ser_out=0, ser_valid=0, ser_last=0.
- The reset takes effect mid-frame too: the partial frame is dropped and no ser_last is issued.
REQ-023 An accept is not possible in a cycle with rst_n=0.

Configuration
REQ-024 With macro SERIAL_NEGATE_TX_PARITY_EN defined:
- State PARITY follows the last data bit and lasts one cycle, with ser_valid=1.
- ser_out equals the even parity (XOR) of the transmitted bits, taken after negation.
- ser_last is asserted only in the PARITY cycle.
- in_ready rises in the PARITY cycle instead of the last data cycle.
- The frame is WIDTH+1 cycles.
REQ-025 Without SERIAL_NEGATE_TX_PARITY_EN, there is no PARITY state, no parity logic and no parity port, and the frame is WIDTH cycles.

Structure
REQ-026 Package serial_negate_pkg holds:
- the state enum type sntx_state_t (IDLE, SHIFT, PARITY);
- the WIDTH default constant SNTX_DEFAULT_WIDTH.
REQ-027 Sub-module serial_negate_bit holds the seen_one flag and the per-bit invert mux. Its inputs are clk, rst_n, clear, neg, bit_valid and raw_bit; its output is the output bit. serial_negate_tx instantiates it once.

Verification
REQ-028 The bench covers these scenarios, with WIDTH=8 unless stated:
- in_data=0x05, in_neg=0 -> bits 1,0,1,0,0,0,0,0; ser_last on the 8th bit; first bit one cycle after accept.
- in_data=0x05, in_neg=1 -> 0xFB, sent as 1,1,0,1,1,1,1,1.
- in_data=0x00 with neg=1 -> 0x00; in_data=0x80 with neg=1 -> 0x80; ser_valid is high for 8 cycles each.
- Back-to-back: in_valid held with 0x3C then 0xA1 (neg=1, giving 0x5F) -> 16 consecutive ser_valid cycles, in_ready high only in the accept cycles.
- rst_n=0 in the 4th bit cycle -> next cycle ser_valid=0 and in_ready=1; no ser_last; a following 0x01 frame is correct.
- With PARITY_EN: 0x07, neg=0 -> 9 bits, parity bit=1, ser_last only on the 9th bit.
